elock_ctrl: RTL

Parametrised successor to the 4-bit single-compare lock: stores a DIGITS x DIGIT_W code entered digit by digit, checks a submitted sequence against it, counts failures and enforces a timed lockout after MAX_FAIL consecutive wrong entries. While open, the stored code can be rewritten through a handshake-checked set sequence. Sits between the keypad/switch debouncing front end and the indicator/actuator drivers.

---
 rtl/elock_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/elock_ctrl.sv
// Multi-digit code lock: digit-by-digit entry, code check, failure counting with timed lockout,
// and code rewrite while open. All outputs registered; checks resolve in one cycle.
module elock_ctrl #(
  parameter int unsigned                   DIGITS       = 4,
  parameter int unsigned                   DIGIT_W      = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]     DEFAULT_CODE = '0,
  parameter int unsigned                   MAX_FAIL     = 3,
  parameter int unsigned                   LOCK_CYCLES  = 1000
) (
  input  logic                             clk0_i,
  input  logic                             reset_i,
  input  logic [DIGIT_W-1:0]               key_val_i,
  input  logic                             key_stb_i,
  input  logic                             enter_i,
  input  logic                             clear_i,
  input  logic                             set_mode_i,
  input  logic                             lock_i,
  output logic                             succ_o,
  output logic                             defeat_o,
  output logic                             lockout_o,
  output logic                             set_done_o,
  output logic                             set_err_o,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt_o
);

  localparam int unsigned CODE_W = DIGITS * DIGIT_W;
  localparam int unsigned CW     = $clog2(DIGITS + 1);
  localparam int unsigned FW     = $clog2(MAX_FAIL + 1);
  localparam int unsigned TW     = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_SET_ENTRY,
    S_LOCKOUT
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                succ_q, defeat_q, lockout_q, set_done_q, set_err_q;
  logic                defeat_d, set_done_d, set_err_d;
  logic                clear_buf, append;
  logic                full, match;

  assign full  = (cnt_q == CW'(DIGITS));
  assign match = full && !ovf_q && (buf_q == code_q);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    defeat_d   = 1'b0;
    set_done_d = 1'b0;
    set_err_d  = 1'b0;
    clear_buf  = 1'b0;
    append     = 1'b0;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (clear_i) begin
          state_d   = S_IDLE;
          clear_buf = 1'b1;
        end else if (enter_i) begin
          clear_buf = 1'b1;
          if (match) begin
            state_d = S_OPEN;
            fail_d  = '0;
          end else begin
            defeat_d = 1'b1;
            fail_d   = fail_q + 1'b1;
            if (fail_q + 1'b1 == FW'(MAX_FAIL)) begin
              state_d = S_LOCKOUT;
              timer_d = TW'(LOCK_CYCLES);
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (key_stb_i) begin
          append  = 1'b1;
          state_d = S_ENTRY;
        end
      end
      S_OPEN: begin
        if (lock_i) begin
          state_d = S_IDLE;
        end else if (set_mode_i) begin
          state_d   = S_SET_ENTRY;
          clear_buf = 1'b1;
        end
      end
      S_SET_ENTRY: begin
        // Relock wins over everything so a half-typed code can always be abandoned silently.
        if (lock_i) begin
          state_d   = S_IDLE;
          clear_buf = 1'b1;
        end else if (clear_i) begin
          state_d   = S_OPEN;
          set_err_d = 1'b1;
          clear_buf = 1'b1;
        end else if (enter_i) begin
          state_d   = S_OPEN;
          clear_buf = 1'b1;
          if (full && !ovf_q) begin
            code_d     = buf_q;
            set_done_d = 1'b1;
          end else begin
            set_err_d = 1'b1;
          end
        end else if (key_stb_i) begin
          append = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer_q <= TW'(1)) begin
          state_d = S_IDLE;
          fail_d  = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clear_buf = 1'b1;
      end
    endcase

    if (clear_buf) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (append) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (cnt_q == CW'(i)) buf_d[i*DIGIT_W +: DIGIT_W] = key_val_i;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk0_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      code_q     <= DEFAULT_CODE;
      buf_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      fail_q     <= '0;
      timer_q    <= '0;
      succ_q     <= 1'b0;
      defeat_q   <= 1'b0;
      lockout_q  <= 1'b0;
      set_done_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      succ_q     <= (state_d == S_OPEN) || (state_d == S_SET_ENTRY);
      defeat_q   <= defeat_d;
      lockout_q  <= (state_d == S_LOCKOUT);
      set_done_q <= set_done_d;
      set_err_q  <= set_err_d;
    end
  end

  assign succ_o     = succ_q;
  assign defeat_o   = defeat_q;
  assign lockout_o  = lockout_q;
  assign set_done_o = set_done_q;
  assign set_err_o  = set_err_q;
  assign fail_cnt_o = fail_q;

endmodule
